// File: rtl/sub_seq_cla_pkg.sv
// rtl/sub_seq_cla_pkg.sv - shared types and constants for the sequential CLA subtractor
//
// Purpose: FSM state encoding, slice width and slice-count helper shared by
//          sub_seq_cla and its testbench.
package sub_seq_cla_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Number of 4-bit slices in an n-bit operand (n is a multiple of 4).
  function automatic int slice_count(input int n);
    return n >> 2;
  endfunction

endpackage

// File: rtl/cla4_slice.sv
// rtl/cla4_slice.sv - 4-bit carry-lookahead adder slice
//
// Purpose: combinational 4-bit add with lookahead carries.
// Ports:
//   a, b  : 4-bit operands
//   cin   : carry in
//   sum   : 4-bit sum
//   cout  : carry out of bit 3
module cla4_slice
  import sub_seq_cla_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Carries expanded directly from generate/propagate, no ripple chain.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];

endmodule

// File: rtl/sub_seq_cla.sv
// rtl/sub_seq_cla.sv - sequential slice-per-cycle subtractor x - y - bin
//
// Purpose: computes x - y - bin as x + ~y + ~bin, one 4-bit CLA slice per
//          clock, LSB first, with valid/ready handshakes on both sides.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   x, y, bin, in_valid      : operands and their valid
//   in_ready                 : operands accepted when in_valid & in_ready
//   diff, bout, zero, ovf    : result and flags, valid while out_valid
//   out_valid, out_ready     : result handshake
module sub_seq_cla
  import sub_seq_cla_pkg::*;
#(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         bin,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         zero,
  output logic         ovf,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int SLICES = slice_count(N);
  localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

  state_e           state_q;
  logic [N-1:0]     x_q;
  logic [N-1:0]     y_q;
  logic [N-1:0]     diff_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;
  logic             xs_q;
  logic             ys_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             bout_q;
  logic             zero_q;
  logic             ovf_q;

  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;
  logic [N+SLICE_W-1:0] diff_shift;

  // Operands shift right each RUN cycle, so the live slice is always bits [3:0].
  cla4_slice u_slice (
    .a    (x_q[SLICE_W-1:0]),
    .b    (~y_q[SLICE_W-1:0]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // New slice enters at the top; after SLICES shifts the LSB slice sits at bit 0.
  assign diff_shift = {slice_sum, diff_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      diff_q      <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      xs_q        <= 1'b0;
      ys_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      bout_q      <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            x_q        <= x;
            y_q        <= y;
            xs_q       <= x[N-1];
            ys_q       <= y[N-1];
            carry_q    <= ~bin;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            zero_q     <= 1'b0;
            ovf_q      <= 1'b0;
            bout_q     <= 1'b0;
            state_q    <= ST_RUN;
          end
        end
        ST_RUN: begin
          x_q     <= x_q >> SLICE_W;
          y_q     <= y_q >> SLICE_W;
          diff_q  <= diff_shift[N+SLICE_W-1:SLICE_W];
          carry_q <= slice_cout;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            bout_q  <= ~slice_cout;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          // First DONE cycle registers the flags from the complete diff,
          // then the result is presented until the consumer takes it.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            zero_q      <= (diff_q == '0);
            ovf_q       <= (xs_q != ys_q) && (diff_q[N-1] != xs_q);
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/sub_seq_cla.md
SUB_SEQ_CLA -- requirements
Module: sub_seq_cla

Interface
REQ-001 Parameter N, default 16, operand width in bits; SHALL be a multiple of 4, with N >= 4.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 x  input  N  minuend; sampled on input handshake.
REQ-005 y  input  N  subtrahend; sampled on input handshake.
REQ-006 bin  input  1  borrow-in; sampled on input handshake.
REQ-007 in_valid  input  1  operands valid.
REQ-008 in_ready  output  1  block accepts operands.
REQ-009 diff  output  N  result: x - y - bin, modulo 2^N.
REQ-010 bout  output  1  borrow-out; 1 when unsigned x < y + bin.
REQ-011 zero  output  1  1 when diff == 0.
REQ-012 ovf  output  1  signed two's-complement overflow of the subtraction.
REQ-013 out_valid  output  1  result valid.
REQ-014 out_ready  input  1  consumer accepts result.

Function
REQ-015 Arithmetic SHALL be x + ~y + cin with cin = ~bin, using 4-bit carry-lookahead generate/propagate logic per slice; bout = ~carry-out of the MSB slice.
REQ-016 The block SHALL process one 4-bit slice per clock, LSB slice first, with the carry held in a 1-bit register between slices.
REQ-017 FSM states: IDLE, RUN, DONE.
REQ-018 IDLE: in_ready=1 and out_valid=0; when in_valid=1, latch x, y and ~bin into the carry register, clear the slice index, and go to RUN.
REQ-019 RUN: in_ready=0 and out_valid=0; each cycle, write slice k of diff and update the carry.
REQ-020 RUN: after slice N/4-1 is written, go to DONE; RUN SHALL last exactly N/4 cycles.
REQ-021 Latency: out_valid SHALL rise N/4+1 cycles after the accepting edge (e.g. 5 cycles for N=16).
REQ-022 DONE: out_valid=1; diff, bout, zero and ovf SHALL be stable, and in_ready=0.
REQ-023 DONE: when out_ready=1, return to IDLE on the next edge; there is no zero-bubble back-to-back acceptance.
REQ-024 ovf SHALL equal (x[N-1] != y[N-1]) && (diff[N-1] != x[N-1]), evaluated on the latched operands.
REQ-025 zero SHALL be derived from the full final diff and is valid only in DONE.
REQ-026 Input changes outside the handshake SHALL NOT affect an operation in progress.
REQ-027 in_valid asserted during RUN or DONE SHALL be ignored; the source holds it until in_ready=1.
REQ-028 The slice index SHALL wrap to 0 on every new acceptance; no slice state is carried across operations.

Reset
REQ-029 rst=1 SHALL, on the next edge, force IDLE with: in_ready=1, out_valid=0, diff=0, bout=0, zero=0, ovf=0, carry=0, index=0.
REQ-030 rst asserted mid-RUN or mid-DONE SHALL abort the operation; no out_valid pulse SHALL follow.
REQ-031 rst SHALL take priority over in_valid and out_ready on the same edge.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, the slice-width constant (4) and the slice-count function N/4.
REQ-033 One sub-module, cla4_slice, SHALL provide 4-bit a, b and cin, producing a 4-bit sum and cout via lookahead; it is instantiated once and reused every cycle.
REQ-034 No multiply or divide operators; no latches; a single clock domain.

Verification (N=16)
REQ-035 x=0x0000, y=0x0001, bin=0 -> diff=0xFFFF, bout=1, zero=0, ovf=0; out_valid exactly 5 cycles after acceptance.
REQ-036 x=0x8000, y=0x0001, bin=0 -> diff=0x7FFF, bout=0, ovf=1.
REQ-037 x=0x1234, y=0x1234, bin=0 -> diff=0x0000, zero=1, bout=0. Then x=0x0005, y=0x0003, bin=1 -> diff=0x0001, bout=0.
REQ-038 Back-pressure: hold out_ready=0 for 3 cycles in DONE -> outputs stable, in_ready=0, and a new in_valid is ignored; out_ready=1 -> IDLE on the next cycle.
REQ-039 Assert rst in the 2nd RUN cycle -> the next cycle shows IDLE with all outputs at reset values and no out_valid; a following operation 0x00FF-0x0F00 -> diff=0xF1FF, bout=1.
REQ-040 Random self-check: 1000 random x, y, bin triples compared against a reference model for diff, bout, zero and ovf, with randomized out_ready stalls.
